// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and the MEM-stage
// request generator.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WORD_SHIFT = 3;
  localparam int LAT_W      = 4;

  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_SD = 7'b0100011;

endpackage

// File: rtl/dmem_array.sv
// MEM_WORDS x 64 storage: one synchronous write port and one combinational read
// port. Word i holds i*INIT_SCALE from time 0; reset never touches the contents.
module dmem_array #(
  parameter int MEM_WORDS  = 1024,
  parameter int INIT_SCALE = 16,
  parameter int AW         = $clog2(MEM_WORDS)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  typedef logic [63:0] mem_t [MEM_WORDS];

  function automatic mem_t preload();
    mem_t m;
    for (int i = 0; i < MEM_WORDS; i++) m[i] = 64'(i) * 64'(INIT_SCALE);
    return m;
  endfunction

  mem_t mem = preload();

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: accepts one doubleword request, waits LATENCY cycles,
// then accesses dmem_array and holds the response until the CPU takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 2,
  parameter int INIT_SCALE = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        resp_is_store
);

  localparam int               AW  = $clog2(MEM_WORDS);
  localparam logic [LAT_W-1:0] LAT = LAT_W'(LATENCY);

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               we_q, we_d;
  logic [63:0]        addr_q, addr_d;
  logic [63:0]        wdata_q, wdata_d;
  logic [63:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               is_store_q, is_store_d;

  logic               accept;
  logic               do_acc;
  logic               acc_we;
  logic               acc_err;
  logic [63:0]        acc_addr;
  logic [63:0]        acc_wdata;
  logic [AW-1:0]      acc_idx;
  logic               arr_we;
  logic [63:0]        arr_rdata;

  // Full 64-bit range compare so a huge address can never alias a low word.
  function automatic logic addr_bad(input logic [63:0] a);
    return (a[WORD_SHIFT-1:0] != '0) || ((a >> WORD_SHIFT) >= 64'(MEM_WORDS));
  endfunction

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // With zero latency the access uses the live request, otherwise the captured one.
  assign acc_we    = (state_q == IDLE) ? req_we    : we_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign acc_err   = addr_bad(acc_addr);
  assign acc_idx   = acc_addr[WORD_SHIFT +: AW];
  assign arr_we    = do_acc && acc_we && !acc_err && !reset;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    is_store_d = is_store_q;
    do_acc     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 0) begin
            do_acc  = 1'b1;
            state_d = RESP;
          end else begin
            wait_cnt_d = LAT;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - LAT_W'(1);
        if (wait_cnt_q == LAT_W'(1)) begin
          do_acc  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (do_acc) begin
      err_d      = acc_err;
      is_store_d = acc_we;
      rdata_d    = (acc_err || acc_we) ? 64'd0 : arr_rdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      is_store_q <= is_store_d;
    end
  end

  assign resp_valid    = (state_q == RESP);
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign resp_is_store = is_store_q;

  dmem_array #(
    .MEM_WORDS (MEM_WORDS),
    .INIT_SCALE(INIT_SCALE),
    .AW        (AW)
  ) u_array (
    .clock(clock),
    .we   (arr_we),
    .waddr(acc_idx),
    .wdata(acc_wdata),
    .raddr(acc_idx),
    .rdata(arr_rdata)
  );

endmodule
